// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// mcause codes, FSM state encoding and arbitrated event kinds.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CAUSE_EBREAK  = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;
  localparam logic [31:0] CAUSE_SOFT    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TIMER   = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT     = 32'h8000_000B;

  typedef enum logic [2:0] {
    S_IDLE, S_W_MEPC, S_W_MCAUSE, S_W_MTVAL, S_W_MSTATUS, S_JUMP, S_M_MSTATUS
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE, EV_ILLEGAL, EV_ECALL, EV_EBREAK, EV_MRET, EV_EXT, EV_SOFT, EV_TIMER
  } event_e;

endpackage

// File: rtl/trap_arb.sv
// Combinational event arbiter: picks the highest-priority pending event
// and its mcause code. Interrupts only qualify on a retire with MIE set.
import trap_ctrl_pkg::*;

module trap_arb (
  input  logic        illegal_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        ext_i,
  input  logic        soft_i,
  input  logic        timer_i,
  input  logic        mie_i,
  input  logic        hx_valid_i,
  output event_e      evt_o,
  output logic [31:0] cause_o
);

  always_comb begin
    evt_o   = EV_NONE;
    cause_o = '0;
    if (illegal_i) begin
      evt_o = EV_ILLEGAL; cause_o = CAUSE_ILLEGAL;
    end else if (ecall_i) begin
      evt_o = EV_ECALL;   cause_o = CAUSE_ECALL;
    end else if (ebreak_i) begin
      evt_o = EV_EBREAK;  cause_o = CAUSE_EBREAK;
    end else if (mret_i) begin
      evt_o = EV_MRET;
    end else if (hx_valid_i && mie_i) begin
      if (ext_i) begin
        evt_o = EV_EXT;   cause_o = CAUSE_EXT;
      end else if (soft_i) begin
        evt_o = EV_SOFT;  cause_o = CAUSE_SOFT;
      end else if (timer_i) begin
        evt_o = EV_TIMER; cause_o = CAUSE_TIMER;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: writes mepc/mcause/mtval/mstatus one per cycle,
// then redirects to mtvec; MRET restores MIE and jumps to mepc.
import trap_ctrl_pkg::*;

module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        hx_valid_i,
  input  logic        ex_trap_valid_i,
  input  logic        tcmp_trap_valid_i,
  input  logic        soft_trap_valid_i,
  input  logic        mstatus_MIE3_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        illegal_i,
  input  logic        mret_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] next_pc_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] mepc_i,
  output logic        trap_csr_we_o,
  output logic [11:0] trap_csr_addr_o,
  output logic [31:0] trap_csr_wdata_o,
  input  logic [31:0] trap_csr_rdata_i,
  output logic        hold_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o
);

  state_e      state_q;
  logic [31:0] cause_q, epc_q, tval_q;
  logic        mret_q;
  event_e      evt;
  logic [31:0] cause;
  logic [31:0] mtvec_base;

  trap_arb u_arb (
    .illegal_i  (illegal_i),
    .ecall_i    (ecall_i),
    .ebreak_i   (ebreak_i),
    .mret_i     (mret_i),
    .ext_i      (ex_trap_valid_i),
    .soft_i     (soft_trap_valid_i),
    .timer_i    (tcmp_trap_valid_i),
    .mie_i      (mstatus_MIE3_i),
    .hx_valid_i (hx_valid_i),
    .evt_o      (evt),
    .cause_o    (cause)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      mret_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (evt == EV_MRET) begin
          state_q <= S_M_MSTATUS;
          mret_q  <= 1'b1;
        end else if (evt != EV_NONE) begin
          state_q <= S_W_MEPC;
          mret_q  <= 1'b0;
          cause_q <= cause;
          epc_q   <= cause[31] ? next_pc_i : inst_addr_i;
          tval_q  <= (evt == EV_ILLEGAL) ? inst_i :
                     (evt == EV_EBREAK)  ? inst_addr_i : 32'h0;
        end
        S_W_MEPC:    state_q <= S_W_MCAUSE;
        S_W_MCAUSE:  state_q <= S_W_MTVAL;
        S_W_MTVAL:   state_q <= S_W_MSTATUS;
        S_W_MSTATUS: state_q <= S_JUMP;
        S_M_MSTATUS: state_q <= S_JUMP;
        S_JUMP:      state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  assign mtvec_base = {trap_csr_rdata_i[31:2], 2'b00};

  // Outputs decode the registered state; rdata feeds through combinationally
  // so the mstatus update and mtvec lookup happen in the writing cycle.
  always_comb begin
    trap_csr_we_o    = 1'b0;
    trap_csr_addr_o  = '0;
    trap_csr_wdata_o = '0;
    hold_o           = 1'b0;
    jump_o           = 1'b0;
    jump_addr_o      = '0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: hold_o = (evt != EV_NONE);
        S_W_MEPC: begin
          hold_o = 1'b1; trap_csr_we_o = 1'b1;
          trap_csr_addr_o = CSR_MEPC;   trap_csr_wdata_o = epc_q;
        end
        S_W_MCAUSE: begin
          hold_o = 1'b1; trap_csr_we_o = 1'b1;
          trap_csr_addr_o = CSR_MCAUSE; trap_csr_wdata_o = cause_q;
        end
        S_W_MTVAL: begin
          hold_o = 1'b1; trap_csr_we_o = 1'b1;
          trap_csr_addr_o = CSR_MTVAL;  trap_csr_wdata_o = tval_q;
        end
        S_W_MSTATUS: begin
          hold_o = 1'b1; trap_csr_we_o = 1'b1;
          trap_csr_addr_o  = CSR_MSTATUS;
          trap_csr_wdata_o = {24'h0, trap_csr_rdata_i[3], 7'h0};
        end
        S_M_MSTATUS: begin
          hold_o = 1'b1; trap_csr_we_o = 1'b1;
          trap_csr_addr_o  = CSR_MSTATUS;
          trap_csr_wdata_o = {24'h0, 1'b1, 3'h0, trap_csr_rdata_i[7], 3'h0};
        end
        S_JUMP: begin
          hold_o = 1'b1; jump_o = 1'b1;
          if (mret_q) begin
            jump_addr_o = mepc_i;
          end else begin
            trap_csr_addr_o = CSR_MTVEC;
            if (trap_csr_rdata_i[1:0] == 2'b01 && cause_q[31])
              jump_addr_o = mtvec_base + 32'({cause_q[30:0], 2'b00});
            else
              jump_addr_o = mtvec_base;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: per-cycle expected CSR-write/jump trace
// derived from the event rules, with random noise on inputs while busy.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hx_valid_i, ex_trap_valid_i, tcmp_trap_valid_i, soft_trap_valid_i;
  logic        mstatus_MIE3_i, ecall_i, ebreak_i, illegal_i, mret_i;
  logic [31:0] inst_addr_i, next_pc_i, inst_i, mepc_i;
  logic        trap_csr_we_o;
  logic [11:0] trap_csr_addr_o;
  logic [31:0] trap_csr_wdata_o, trap_csr_rdata_i;
  logic        hold_o, jump_o;
  logic [31:0] jump_addr_o;

  logic [31:0] mstatus_v, mtvec_v;
  int checks = 0;
  int failures = 0;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .hx_valid_i(hx_valid_i),
    .ex_trap_valid_i(ex_trap_valid_i), .tcmp_trap_valid_i(tcmp_trap_valid_i),
    .soft_trap_valid_i(soft_trap_valid_i), .mstatus_MIE3_i(mstatus_MIE3_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .illegal_i(illegal_i), .mret_i(mret_i),
    .inst_addr_i(inst_addr_i), .next_pc_i(next_pc_i), .inst_i(inst_i), .mepc_i(mepc_i),
    .trap_csr_we_o(trap_csr_we_o), .trap_csr_addr_o(trap_csr_addr_o),
    .trap_csr_wdata_o(trap_csr_wdata_o), .trap_csr_rdata_i(trap_csr_rdata_i),
    .hold_o(hold_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
  );

  always #5 clk = ~clk;

  // CSR file model: only mstatus and mtvec are ever read by the block.
  assign trap_csr_rdata_i = (trap_csr_addr_o == 12'h300) ? mstatus_v :
                            (trap_csr_addr_o == 12'h305) ? mtvec_v : 32'h0;

  // Observation record: {we, addr, wdata, hold, jump, jaddr}
  function automatic logic [78:0] rec(logic we, logic [11:0] a, logic [31:0] wd,
                                      logic h, logic j, logic [31:0] ja);
    return {we, a, wd, h, j, ja};
  endfunction

  function automatic logic [78:0] observe();
    return {trap_csr_we_o, trap_csr_addr_o, trap_csr_wdata_o, hold_o, jump_o, jump_addr_o};
  endfunction

  // rq = {illegal, ecall, ebreak, mret, ext, soft, timer}
  function automatic int pick(logic [6:0] rq, logic mie, logic hx);
    if (rq[6]) return 1;
    if (rq[5]) return 2;
    if (rq[4]) return 3;
    if (rq[3]) return 4;
    if (mie && hx) begin
      if (rq[2]) return 5;
      if (rq[1]) return 6;
      if (rq[0]) return 7;
    end
    return 0;
  endfunction

  task automatic drive(logic [6:0] rq, logic mie, logic hx,
                       logic [31:0] pc, logic [31:0] npc, logic [31:0] inst);
    {illegal_i, ecall_i, ebreak_i, mret_i, ex_trap_valid_i, soft_trap_valid_i,
     tcmp_trap_valid_i} = rq;
    mstatus_MIE3_i = mie; hx_valid_i = hx;
    inst_addr_i = pc; next_pc_i = npc; inst_i = inst;
  endtask

  task automatic run_event(string nm, logic [6:0] rq, logic mie, logic hx,
                           logic [31:0] pc, logic [31:0] npc, logic [31:0] inst,
                           logic [31:0] mepc, logic [31:0] ms, logic [31:0] tv);
    int ev;
    logic [31:0] cause, epc, tval, tgt;
    logic [78:0] exp_q[$];
    logic [78:0] obs, e;
    int unsigned cause_tab[8] = '{0, 32'h2, 32'hB, 32'h3, 0,
                                  32'h8000_000B, 32'h8000_0003, 32'h8000_0007};
    ev = pick(rq, mie, hx);
    cause = cause_tab[ev];
    epc  = cause[31] ? npc : pc;
    tval = (ev == 1) ? inst : (ev == 3) ? pc : 32'h0;
    if (tv[1:0] == 2'b01 && cause[31])
      tgt = (tv & 32'hFFFF_FFFC) + 4 * (cause & 32'h7FFF_FFFF);
    else
      tgt = tv & 32'hFFFF_FFFC;
    exp_q.push_back(rec(0, 0, 0, ev != 0, 0, 0));
    if (ev == 4) begin
      exp_q.push_back(rec(1, 12'h300, 32'h80 | (ms[7] ? 32'h8 : 32'h0), 1, 0, 0));
      exp_q.push_back(rec(0, 0, 0, 1, 1, mepc));
    end else if (ev != 0) begin
      exp_q.push_back(rec(1, 12'h341, epc, 1, 0, 0));
      exp_q.push_back(rec(1, 12'h342, cause, 1, 0, 0));
      exp_q.push_back(rec(1, 12'h343, tval, 1, 0, 0));
      exp_q.push_back(rec(1, 12'h300, ms[3] ? 32'h80 : 32'h0, 1, 0, 0));
      exp_q.push_back(rec(0, 12'h305, 0, 1, 1, tgt));
    end
    exp_q.push_back(rec(0, 0, 0, 0, 0, 0));

    @(posedge clk); #1;
    mstatus_v = ms; mtvec_v = tv; mepc_i = mepc;
    drive(rq, mie, hx, pc, npc, inst);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs = observe();
      e = exp_q[i];
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s cyc%0d: got we=%b addr=%h wdata=%h hold=%b jump=%b jaddr=%h ; want we=%b addr=%h wdata=%h hold=%b jump=%b jaddr=%h",
                 nm, i, obs[78], obs[77:66], obs[65:34], obs[33], obs[32], obs[31:0],
                 e[78], e[77:66], e[65:34], e[33], e[32], e[31:0]);
      end
      @(posedge clk); #1;
      if (i + 1 < exp_q.size() - 1)
        drive(7'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
      else
        drive(7'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(7'($urandom) | 7'h20, 1'b1, 1'b1, $urandom, $urandom, $urandom);
      mepc_i = $urandom;
      @(negedge clk);
      checks++;
      if (observe() !== 79'h0) begin
        failures++;
        $display("FAIL reset_outputs: got %h want 0", observe());
      end
    end
    @(posedge clk); #1;
    drive(7'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (observe() !== 79'h0) begin
      failures++;
      $display("FAIL reset_release_idle: got %h want 0", observe());
    end
  endtask

  task automatic test_directed();
    run_event("ext_int",   7'b0000100, 1, 1, 32'h100, 32'h104, 32'h13, 0, 32'h8, 32'h200);
    run_event("illegal",   7'b1000001, 1, 1, 32'h80, 32'h84, 32'hFFFF_FFFF, 0, 32'h8, 32'h200);
    run_event("timer_vec", 7'b0000001, 1, 1, 32'h40, 32'h44, 32'h13, 0, 32'h8, 32'h201);
    run_event("ecall_vec", 7'b0100000, 1, 1, 32'h40, 32'h44, 32'h73, 0, 32'h8, 32'h201);
    run_event("ebreak",    7'b0010000, 0, 0, 32'h3C, 32'h40, 32'h100073, 0, 32'h0, 32'h300);
    run_event("mret",      7'b0001000, 0, 0, 32'h60, 32'h64, 32'h30200073, 32'h104, 32'h80, 32'h200);
  endtask

  task automatic test_no_accept();
    run_event("soft_mie0", 7'b0000010, 0, 1, 32'h10, 32'h14, 0, 0, 32'h8, 32'h200);
    run_event("soft_hx0",  7'b0000010, 1, 0, 32'h10, 32'h14, 0, 0, 32'h8, 32'h200);
    run_event("soft_ok",   7'b0000010, 1, 1, 32'h10, 32'h14, 0, 0, 32'h8, 32'h401);
  endtask

  task automatic test_reset_mid();
    logic [78:0] obs;
    @(posedge clk); #1;
    mstatus_v = 32'h8; mtvec_v = 32'h200;
    drive(7'b0100000, 0, 0, 32'h50, 32'h54, 32'h73);
    @(posedge clk); #1;               // now W_MEPC
    drive(7'h0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;               // now W_MCAUSE
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (observe() !== 79'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got %h want 0", observe());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = observe();
      checks++;
      if (obs !== 79'h0) begin
        failures++;
        $display("FAIL rst_mid_no_write cyc%0d: got %h want 0", i, obs);
      end
      @(posedge clk); #1;
    end
    run_event("ecall_after_rst", 7'b0100000, 0, 0, 32'h50, 32'h54, 32'h73, 0, 32'h8, 32'h200);
  endtask

  task automatic test_random();
    logic [31:0] tv;
    for (int n = 0; n < 40; n++) begin
      tv = $urandom;
      tv[1] = 1'b0;
      run_event("random", 7'($urandom & $urandom), 1'($urandom), 1'($urandom),
                $urandom, $urandom, $urandom, $urandom, $urandom, tv);
    end
  endtask

  initial begin
    rst = 1'b1;
    mstatus_v = 0; mtvec_v = 0; mepc_i = 0;
    drive(7'h0, 0, 0, 0, 0, 0);
    @(posedge clk);
    test_reset();
    test_directed();
    test_no_accept();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
